// File: rtl/fifo_rd_byte_serializer.sv
// fifo_rd_byte_serializer
//   Pops DW-bit words from the read side of a FIFO and emits them as a
//   BW-bit valid/ready beat stream. A one-word prefetch slot sits between the
//   FIFO and the shift register. It hides the one-cycle FIFO read latency, so
//   consecutive words leave back to back while m_ready stays high.
//
//   Beat order is LSB-first by default.
//   Defining SER_MSB_FIRST_EN makes beats leave MSB-first. Handshake, timing
//   and m_last are the same in both builds.
//
// Ports
//   CLK         clock shared by the FIFO read side and the stream
//   RST         synchronous reset, active-high
//   fifo_rdata  FIFO read data, valid one CLK after fifo_rd_en
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  pop strobe, one cycle per word
//   m_data      current beat
//   m_valid     beat valid
//   m_ready     sink accepts beat
//   m_last      final beat of a word
//   busy        a read is pending or a word is held

module fifo_rd_byte_serializer #(
    parameter int DW = 32,
    parameter int BW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] fifo_rdata,
    input  logic          fifo_empty,
    output logic          fifo_rd_en,
    output logic [BW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          busy
);

    // DW must be a multiple of BW with at least two beats per word.
    localparam int NB = DW / BW;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);

    logic          pend;      // read strobe issued last cycle, data arrives now
    logic [DW-1:0] pf_reg;
    logic          pf_valid;
    logic [DW-1:0] sr_reg;
    logic          sr_valid;
    logic [CW-1:0] beat_cnt;

    logic xfer;
    logic last_xfer;
    logic sr_load;

    // A new read is issued only when nothing is in flight and the prefetch
    // slot is free. Because of that, a FIFO capture and a prefetch-to-shift
    // load can never target the same slot in the same cycle.
    assign fifo_rd_en = !RST && !fifo_empty && !pend && !pf_valid;

    assign xfer      = sr_valid && m_ready;
    assign last_xfer = xfer && (beat_cnt == LAST_BEAT);
    assign sr_load   = (!sr_valid || last_xfer) && pf_valid;

    assign m_valid = sr_valid;
    assign m_last  = sr_valid && (beat_cnt == LAST_BEAT);
    assign busy    = pend || pf_valid || sr_valid;

`ifdef SER_MSB_FIRST_EN
    assign m_data = sr_reg[DW-1:DW-BW];
`else
    assign m_data = sr_reg[BW-1:0];
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            pend     <= 1'b0;
            pf_reg   <= '0;
            pf_valid <= 1'b0;
            sr_reg   <= '0;
            sr_valid <= 1'b0;
            beat_cnt <= '0;
        end else begin
            pend <= fifo_rd_en;

            // pend implies pf_valid was clear when the read issued, so the
            // capture and the load branch below are mutually exclusive.
            if (pend) begin
                pf_reg   <= fifo_rdata;
                pf_valid <= 1'b1;
            end else if (sr_load) begin
                pf_valid <= 1'b0;
            end

            if (sr_load) begin
                sr_reg   <= pf_reg;
                sr_valid <= 1'b1;
                beat_cnt <= '0;
            end else if (last_xfer) begin
                sr_valid <= 1'b0;
                beat_cnt <= '0;
            end else if (xfer) begin
`ifdef SER_MSB_FIRST_EN
                sr_reg   <= sr_reg << BW;
`else
                sr_reg   <= sr_reg >> BW;
`endif
                beat_cnt <= beat_cnt + CW'(1);
            end
        end
    end

endmodule

// File: doc/fifo_rd_byte_serializer.md
Name: fifo_rd_byte_serializer

Overview:
- Downstream consumer of the read side of the 32-bit FIFO; pops words via a single-cycle read strobe.
- Serializes each word into a BW-bit valid/ready byte stream toward the PS-facing peripheral logic.
- One-word prefetch register hides the FIFO read latency, so consecutive words stream without bubbles while m_ready stays high.

Parameters:
- DW, 32, FIFO word width; must be an integer multiple of BW.
- BW, 8, output beat width; DW/BW must be at least 2.
- NB, DW/BW, beats per word (derived; not overridden).

Ports:
- CLK  input  1  clock; FIFO read side and stream share this domain.
- RST  input  1  synchronous reset, active-high.
- fifo_rdata  input  DW  FIFO read data, valid exactly one CLK after fifo_rd_en.
- fifo_empty  input  1  FIFO empty flag, read-domain.
- fifo_rd_en  output  1  pop strobe, one cycle per word.
- m_data  output  BW  current beat.
- m_valid  output  1  beat valid.
- m_ready  input  1  sink accepts beat.
- m_last  output  1  high on the final beat of a word.
- busy  output  1  high when a read is pending or any word is held.

Behaviour:
- Reset is synchronous; the following are forced at the CLK edge while RST=1: m_valid=0, m_data=0, m_last=0, fifo_rd_en=0, busy=0.
- Reset also clears pend, pf_valid, sr_valid and beat_cnt.
- Reset mid-operation discards the shift and prefetch words and any read in flight; that word is lost. This is accepted behaviour.
- Internal state:
  - pend: read issued last cycle.
  - pf_reg/pf_valid: prefetch slot.
  - sr_reg/sr_valid: shift register.
  - beat_cnt: 0..NB-1.
- fifo_rd_en = !RST && !fifo_empty && !pend && !pf_valid. It is combinational from registers plus fifo_empty, and never asserts while fifo_empty=1.
- pend <= fifo_rd_en. When pend=1, fifo_rdata is captured into pf_reg and pf_valid is set.
- Handshake: a beat transfers when m_valid && m_ready.
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable.
  - m_valid never drops without a transfer, except on reset.
- m_valid = sr_valid.
- m_data = sr_reg[BW-1:0]; this is LSB-first by default.
- m_last = sr_valid && beat_cnt==NB-1.
- On a non-last transfer: sr_reg shifts right by BW, zero-filled, and beat_cnt increments.
- Shift-register load occurs when (!sr_valid || last-beat transfer) && pf_valid:
  - sr_reg <= pf_reg, beat_cnt <= 0, pf_valid cleared, sr_valid=1.
- Last-beat transfer with no prefetch word: sr_valid <= 0 and beat_cnt <= 0.
- Simultaneous events:
  - Capture into pf and load from pf in the same cycle: the capture is blocked, because fifo_rd_en requires !pf_valid, so the two cannot collide.
  - When pf_valid is freed by a load, a new rd_en may assert in the following cycle.
- Throughput: with m_ready=1 continuously, beats are gap-free across word boundaries when NB>=3. For NB=2, a 1-cycle bubble per word is permitted.
- First-word latency: rd_en at cycle t, pf_valid at t+2, m_valid at t+3.
- busy = pend || pf_valid || sr_valid.
- The block never underflows the FIFO and never drops a word outside of reset.

Optional Feature:
- SER_MSB_FIRST_EN defined:
  - m_data = sr_reg[DW-1:DW-BW].
  - Shift is left by BW, zero-filled.
  - Bytes leave MSB-first.
- Undefined: LSB-first as above. Handshake, timing and m_last are identical in both builds.

Test Plan:
- Reset check: RST=1 for 2 cycles with fifo_empty=0 -> fifo_rd_en=0, m_valid=0, m_data=0, busy=0 throughout.
- Single word, LSB-first: FIFO holds 0xA1B2C3D4, m_ready=1 -> beats D4, C3, B2, A1 on consecutive cycles; m_last only on A1; exactly one fifo_rd_en pulse; busy=0 afterwards.
- Back-to-back words: FIFO holds 0x03020100 and 0x07060504, m_ready=1 -> 8 consecutive beats 00..07 with no gap; m_last on 03 and 07; two rd_en pulses.
- Backpressure: m_ready low for 5 cycles at beat 2 of 0x11223344 -> m_data=0x22 and m_valid=1 held stable for all 5 cycles; no extra rd_en while pf_valid=1; stream resumes with 0x11.
- Empty boundary: fifo_empty toggles 1/0 on alternate cycles -> fifo_rd_en never high while fifo_empty=1; every popped word emitted once, in order.
- MSB-first build (SER_MSB_FIRST_EN): word 0xA1B2C3D4 -> beats A1, B2, C3, D4; m_last on D4.
